// File: rtl/pif_regctl.sv
// Register-access controller: decodes I2C command bytes, owns the LED config
// bank with an auto-incrementing pointer, and serves read bytes back to the slave.
module pif_regctl #(
    parameter int         NREGS  = 4,
    parameter logic [5:0] ID_VAL = 6'h2A,
    parameter logic [1:0] A_CODE = 2'b00,
    parameter logic [1:0] D_CODE = 2'b01
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       STOP,
    input  logic       RXV,
    input  logic [7:0] RXD,
    input  logic       RDREQ,
    output logic       TXV,
    output logic [7:0] TXD,
    output logic       LED_SYNC,
    output logic       LED_EN,
    output logic [5:0] LED_RATE,
    output logic       CFG_UPD,
    output logic       ERR
);

    localparam int PW = (NREGS > 1) ? $clog2(NREGS) : 1;
    // Bank is sized to cover every pointer code and always holds reg2/reg3.
    localparam int NB = ((2 ** PW) < 4) ? 4 : (2 ** PW);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_READ} state_t;

    state_t         state_q, state_d;
    logic           ret_active_q, ret_active_d;
    logic           rd_pend_q, rd_pend_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [5:0]     bank_q [NB];
    logic [5:0]     bank_d [NB];
    logic           txv_q, txv_d;
    logic [7:0]     txd_q, txd_d;
    logic           cfg_upd_q, cfg_upd_d;
    logic           err_q, err_d;

    logic           base_active;
    logic           next_active;
    logic           rd_req;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (int'(p) == NREGS - 1)
            return '0;
        else
            return p + PW'(1);
    endfunction

    always_comb begin
        state_d      = state_q;
        ret_active_d = ret_active_q;
        rd_pend_d    = 1'b0;
        ptr_d        = ptr_q;
        bank_d       = bank_q;
        txv_d        = 1'b0;
        txd_d        = txd_q;
        cfg_upd_d    = 1'b0;
        err_d        = err_q;

        // READ is a one-cycle detour; the transaction state lives on in ret_active_q.
        base_active = (state_q == S_READ) ? ret_active_q : (state_q == S_ACTIVE);

        if (RXV) begin
            if (!base_active) begin
                err_d = 1'b1;
            end else if (RXD[7:6] == A_CODE) begin
                ptr_d = PW'(int'(RXD[5:0]) % NREGS);
            end else if (RXD[7:6] == D_CODE) begin
                if (ptr_q != '0) begin
                    bank_d[ptr_q] = RXD[5:0];
                    if (int'(ptr_q) == 1)
                        err_d = 1'b0;
                    if (int'(ptr_q) == 2 || int'(ptr_q) == 3)
                        cfg_upd_d = 1'b1;
                end
                ptr_d = ptr_inc(ptr_q);
            end else begin
                err_d = 1'b1;
            end
        end

        if (RDREQ && rd_pend_q)
            err_d = 1'b1;

        // A byte in the same cycle owns the pointer, so the read waits a cycle.
        rd_req = RDREQ | rd_pend_q;
        if (rd_req && RXV) begin
            rd_pend_d = 1'b1;
        end else if (rd_req) begin
            txv_d = 1'b1;
            txd_d = {2'b00, bank_q[ptr_q]};
            ptr_d = ptr_inc(ptr_q);
        end

        next_active = STOP ? 1'b0 : (START ? 1'b1 : base_active);
        if (txv_d) begin
            state_d      = S_READ;
            ret_active_d = next_active;
        end else begin
            state_d = next_active ? S_ACTIVE : S_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            ret_active_q <= 1'b0;
            rd_pend_q    <= 1'b0;
            ptr_q        <= '0;
            for (int i = 0; i < NB; i++)
                bank_q[i] <= 6'd0;
            bank_q[0]    <= ID_VAL;
            bank_q[2]    <= 6'b000010;
            bank_q[3]    <= 6'd20;
            txv_q        <= 1'b0;
            txd_q        <= 8'd0;
            cfg_upd_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_active_q <= ret_active_d;
            rd_pend_q    <= rd_pend_d;
            ptr_q        <= ptr_d;
            bank_q       <= bank_d;
            txv_q        <= txv_d;
            txd_q        <= txd_d;
            cfg_upd_q    <= cfg_upd_d;
            err_q        <= err_d;
        end
    end

    assign TXV      = txv_q;
    assign TXD      = txd_q;
    assign LED_SYNC = bank_q[2][0];
    assign LED_EN   = bank_q[2][1];
    assign LED_RATE = bank_q[3];
    assign CFG_UPD  = cfg_upd_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_pif_regctl.sv
// Testbench for pif_regctl: directed test-plan walk followed by random traffic,
// every cycle compared against a transaction-level register-bank model.
module tb_pif_regctl;

    localparam int         N  = 4;
    localparam logic [5:0] ID = 6'h2A;

    logic       clk = 1'b0;
    logic       rst, start, stop, rxv, rdreq;
    logic [7:0] rxd;
    logic       txv;
    logic [7:0] txd;
    logic       led_sync, led_en, cfg_upd, err;
    logic [5:0] led_rate;

    int n_vectors     = 0;
    int n_checks      = 0;
    int n_miscompares = 0;

    // Reference model: plain register array, integer pointer, transaction flag.
    int m_regs [N];
    int m_ptr;
    bit m_active, m_pend, m_txv, m_txd_valid, m_cfg, m_err;
    int m_txd;

    always #5 clk = ~clk;

    pif_regctl #(.NREGS(N), .ID_VAL(ID), .A_CODE(2'b00), .D_CODE(2'b01)) dut (
        .CLK(clk), .RST(rst), .START(start), .STOP(stop), .RXV(rxv), .RXD(rxd),
        .RDREQ(rdreq), .TXV(txv), .TXD(txd), .LED_SYNC(led_sync), .LED_EN(led_en),
        .LED_RATE(led_rate), .CFG_UPD(cfg_upd), .ERR(err)
    );

    task automatic modelReset();
        for (int i = 0; i < N; i++) m_regs[i] = 0;
        m_regs[0] = int'(ID);
        m_regs[2] = 2;
        m_regs[3] = 20;
        m_ptr = 0; m_active = 0; m_pend = 0;
        m_txv = 0; m_txd = 0; m_txd_valid = 1; m_cfg = 0; m_err = 0;
    endtask

    task automatic modelStep(input bit i_start, input bit i_stop, input bit i_rxv,
                             input logic [7:0] i_rxd, input bit i_rdreq, input bit i_rst);
        int code, payload;
        bit want;
        if (i_rst) begin
            modelReset();
            return;
        end
        m_txv = 0; m_cfg = 0; m_txd_valid = 0;
        if (i_rxv) begin
            code    = int'(i_rxd) / 64;
            payload = int'(i_rxd) % 64;
            if (!m_active) m_err = 1;
            else if (code == 0) m_ptr = payload % N;
            else if (code == 1) begin
                if (m_ptr != 0) begin
                    m_regs[m_ptr] = payload;
                    if (m_ptr == 1) m_err = 0;
                    if (m_ptr == 2 || m_ptr == 3) m_cfg = 1;
                end
                m_ptr = (m_ptr + 1) % N;
            end else m_err = 1;
        end
        if (i_rdreq && m_pend) m_err = 1;
        want = i_rdreq || m_pend;
        m_pend = 0;
        if (want) begin
            if (i_rxv) m_pend = 1;
            else begin
                m_txv = 1; m_txd_valid = 1;
                m_txd = m_regs[m_ptr];
                m_ptr = (m_ptr + 1) % N;
            end
        end
        if (i_stop) m_active = 0;
        else if (i_start) m_active = 1;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkValue("TXV", 32'(txv), 32'(m_txv));
        if (m_txd_valid) checkValue("TXD", 32'(txd), 32'(m_txd));
        checkValue("LED_SYNC", 32'(led_sync), 32'(m_regs[2] % 2));
        checkValue("LED_EN", 32'(led_en), 32'((m_regs[2] / 2) % 2));
        checkValue("LED_RATE", 32'(led_rate), 32'(m_regs[3]));
        checkValue("CFG_UPD", 32'(cfg_upd), 32'(m_cfg));
        checkValue("ERR", 32'(err), 32'(m_err));
    endtask

    task automatic applyStimulus(input bit i_start, input bit i_stop, input bit i_rxv,
                                 input logic [7:0] i_rxd, input bit i_rdreq, input bit i_rst);
        @(negedge clk);
        start = i_start; stop = i_stop; rxv = i_rxv; rxd = i_rxd; rdreq = i_rdreq; rst = i_rst;
        @(posedge clk);
        modelStep(i_start, i_stop, i_rxv, i_rxd, i_rdreq, i_rst);
        #1;
        n_vectors++;
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 8'h00, 0, 0);
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(0, 0, 1, b, 0, 0);
    endtask

    task automatic readReq();
        applyStimulus(0, 0, 0, 8'h00, 1, 0);
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; rxv = 0; rdreq = 0; rxd = 8'h00;
        modelReset();

        // Reset, then idle
        applyStimulus(0, 0, 0, 8'h00, 0, 1);
        applyStimulus(0, 0, 0, 8'h00, 0, 1);
        idle();
        checkValue("rst_led_en", 32'(led_en), 32'd1);
        checkValue("rst_led_rate", 32'(led_rate), 32'd20);
        checkValue("rst_err", 32'(err), 32'd0);
        checkValue("rst_txd", 32'(txd), 32'd0);

        // Single write to reg2
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        sendByte(8'h02);
        sendByte(8'h41);
        checkValue("sync_after_write", 32'(led_sync), 32'd1);
        checkValue("cfg_pulse", 32'(cfg_upd), 32'd1);
        applyStimulus(0, 1, 0, 8'h00, 0, 0);
        checkValue("cfg_once", 32'(cfg_upd), 32'd0);
        readReq();
        checkValue("ptr3_txv", 32'(txv), 32'd1);
        checkValue("ptr3_txd", 32'(txd), 32'h14);
        idle();

        // Burst write with wrap through reg0
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        sendByte(8'h03);
        sendByte(8'h45);
        checkValue("burst_rate", 32'(led_rate), 32'd5);
        checkValue("burst_cfg", 32'(cfg_upd), 32'd1);
        sendByte(8'h47);
        checkValue("reg0_no_cfg", 32'(cfg_upd), 32'd0);
        applyStimulus(0, 1, 0, 8'h00, 0, 0);
        readReq();
        checkValue("ptr1_txd", 32'(txd), 32'h00);
        idle();

        // Read sequence on a reset bank
        applyStimulus(0, 0, 0, 8'h00, 0, 1);
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        sendByte(8'h00);
        readReq();
        checkValue("rd0", 32'(txd), 32'h2A);
        readReq();
        checkValue("rd1", 32'(txd), 32'h00);
        readReq();
        checkValue("rd2", 32'(txd), 32'h02);
        idle();
        checkValue("txv_one_cycle", 32'(txv), 32'd0);

        // Collision, reserved code, ERR clear, overrun
        applyStimulus(0, 0, 1, 8'h41, 1, 0);
        checkValue("coll_no_txv", 32'(txv), 32'd0);
        idle();
        checkValue("coll_txv", 32'(txv), 32'd1);
        checkValue("coll_txd", 32'(txd), 32'h2A);
        sendByte(8'hC5);
        checkValue("reserved_err", 32'(err), 32'd1);
        checkValue("reserved_rate", 32'(led_rate), 32'd1);
        sendByte(8'h01);
        sendByte(8'h41);
        checkValue("err_clear", 32'(err), 32'd0);
        applyStimulus(0, 0, 1, 8'h00, 1, 0);
        readReq();
        checkValue("overrun_err", 32'(err), 32'd1);
        checkValue("overrun_txv", 32'(txv), 32'd1);
        idle();
        applyStimulus(0, 1, 0, 8'h00, 0, 0);

        // Reset mid-transaction
        applyStimulus(0, 0, 0, 8'h00, 0, 1);
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        sendByte(8'h03);
        applyStimulus(0, 0, 1, 8'h7F, 0, 1);
        checkValue("midrst_rate", 32'(led_rate), 32'd20);
        sendByte(8'h43);
        checkValue("byte_outside_err", 32'(err), 32'd1);
        readReq();
        checkValue("midrst_ptr0", 32'(txd), 32'h2A);

        // Address payload wraps modulo NREGS
        applyStimulus(1, 0, 0, 8'h00, 0, 0);
        sendByte(8'h07);
        readReq();
        checkValue("addr_mod", 32'(txd), 32'h14);
        applyStimulus(1, 1, 0, 8'h00, 0, 0);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            bit r_st, r_sp, r_rx, r_rd, r_rs;
            int sel;
            logic [1:0] code;
            r_rs = ($urandom_range(0, 99) == 0);
            r_st = ($urandom_range(0, 9) == 0);
            r_sp = ($urandom_range(0, 11) == 0);
            r_rx = ($urandom_range(0, 9) < 4);
            r_rd = ($urandom_range(0, 4) == 0);
            sel  = $urandom_range(0, 9);
            code = (sel < 4) ? 2'b00 : (sel < 9) ? 2'b01 : 2'($urandom_range(2, 3));
            applyStimulus(r_st, r_sp, r_rx, {code, 6'($urandom_range(0, 63))}, r_rd, r_rs);
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
